comparator_sequential: RTL and testbench
========================================

# comparator_sequential

Multi-cycle, parametrised-width comparator producing the full `signals::compare_t` flag set (eq, neq, gt, lt, gtu, ltu). It scans operands MSB-first in CHUNK-bit slices, one slice per cycle, and terminates early on the first differing slice. It exchanges operands and results over valid/ready handshakes. It sits beside the ALU for wide compares where a single-cycle N-bit compare would break timing, and reports how many slice steps each compare used.

## Interface
- N, default 32: operand width; N % CHUNK == 0 is mandatory.
- CHUNK, default 8: bits compared per cycle; 1 ≤ CHUNK ≤ N.
- STEPS, derived, N/CHUNK: maximum scan cycles. Not overridable.
- SW, derived, $clog2(STEPS+1): width of the steps port.
- clk, input, 1: clock. All state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous abort. Overrides all other inputs.
- in_valid, input, 1: a/b are valid.
- in_ready, output, 1: the block accepts operands. Combinational: (state == IDLE) & ~flush.
- a, input, N: operand A.
- b, input, N: operand B.
- out_valid, output, 1: signal/steps hold a result. Registered.
- out_ready, input, 1: consumer takes the result.
- signal, output, signals::compare_t: comparison flags. Registered.
- steps, output, SW: slices scanned for this result, 1..STEPS. Registered.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - An in_valid & in_ready edge latches a and b into ra and rb, clears idx to 0, and moves to SCAN.
- SCAN: each cycle compares the slice at s = STEPS-1-idx, i.e. bits [s*CHUNK +: CHUNK] of ra and rb.
  - Slices differ: record ugt = (ra slice > rb slice), ult = ~ugt, eq = 0. Load the flags and steps = idx+1, then go to DONE.
  - Slices equal and idx == STEPS-1: eq = 1, ugt = ult = 0. Load the flags and steps = STEPS, then go to DONE.
  - Otherwise: idx increments and the state stays SCAN.
- Flag derivation, with sa = ra[N-1] and sb = rb[N-1]:
  - neq = ~eq.
  - gtu = ugt; ltu = ult.
  - gt = (~sa & sb) | ((sa == sb) & ugt).
  - lt = (sa & ~sb) | ((sa == sb) & ult).
- Exactly one of {eq, gtu, ltu} and at most one of {gt, lt} is set in any result.
- DONE:
  - out_valid = 1; signal and steps are held stable.
  - out_ready high: out_valid clears on the next edge and the state returns to IDLE.
  - in_ready stays 0 in DONE. There is no overlap of a new accept with a pending result.
- flush = 1, any state: on the next edge go to IDLE, out_valid = 0, signal = 0, steps = 0.
  - No accept happens in a flush cycle, because in_ready is forced low.
- Reset (async, reset_n low):
  - state = IDLE, out_valid = 0, signal = all zeros, steps = 0, idx = 0, ra = rb = 0.
  - in_ready reads 1 while in reset, unless flush is high.
  - Reset mid-SCAN or mid-DONE discards the operation; no result is produced.
- Operand changes on a and b after the accept edge have no effect.

## Timing
- Accept at edge T0. The slice that ends the scan is compared in cycle T0+k-1, where k = steps; out_valid rises at edge T0+k.
- Latency bounds:
  - Minimum 1 cycle: the MSB slice differs.
  - Maximum STEPS cycles: the operands are equal, or they differ only in the LSB slice.
- Result consumed at edge Td (out_valid & out_ready): out_valid = 0 and in_ready = 1 after Td. The earliest next accept is edge Td+1.
- Throughput per compare: k + 2 cycles with out_ready tied high.
- CHUNK = N gives a 1-cycle scan. CHUNK = 1 gives a bit-serial scan of N cycles.

## Structure
- Package signals:
  - compare_t is reused unchanged.
  - Add typedef enum logic[1:0] {CMPS_IDLE, CMPS_SCAN, CMPS_DONE} cmp_seq_state_t.
- Sub-module comparator_slice #(CHUNK): purely combinational.
  - Inputs: two CHUNK-bit slices. Outputs: gt and eq.
  - Instantiated once, fed by a slice mux driven by idx.
- Elaboration-time assertion: N % CHUNK == 0.

## Test plan
- N=32, CHUNK=8, a=0x80000000, b=0x00000000 → steps=1, out_valid 1 cycle after accept; gtu=1, lt=1, neq=1, others 0.
- a=0x12345678, b=0x12345679 → steps=4, latency 4; ltu=1, lt=1, neq=1.
- a=b=0xDEADBEEF → steps=4; eq=1, all other flags 0.
- a=0xFFFFFFFF, b=0xFFFFFFFE with out_ready held low 5 cycles → steps=4; gtu=1, gt=1.
  - signal and out_valid stay stable until out_ready, and in_ready stays 0 throughout.
- flush asserted in the 2nd SCAN cycle of a=1, b=2 → next edge: IDLE, out_valid=0, no result emitted; next accept works normally.
- reset_n pulsed low mid-SCAN → outputs immediately zero, out_valid=0; then repeat the previous cases with CHUNK=1 and CHUNK=32, checking steps and latency.

Source files
------------

// File: rtl/comparator_sequential_pkg.sv
// Shared types for the sequential comparator: the compare flag set, the
// scan FSM state encoding and the flag derivation from the scan outcome.
package signals;

    typedef struct packed {
        logic eq;
        logic neq;
        logic gt;
        logic lt;
        logic gtu;
        logic ltu;
    } compare_t;

    typedef enum logic [1:0] {
        CMPS_IDLE,
        CMPS_SCAN,
        CMPS_DONE
    } cmp_seq_state_t;

    // Builds the full flag set from the unsigned scan outcome and the two
    // operand sign bits; signed order only differs from unsigned when the
    // sign bits disagree.
    function automatic compare_t make_compare(
        input logic eq,
        input logic ugt,
        input logic ult,
        input logic sa,
        input logic sb
    );
        compare_t f;
        f.eq  = eq;
        f.neq = ~eq;
        f.gtu = ugt;
        f.ltu = ult;
        f.gt  = (~sa & sb) | ((sa == sb) & ugt);
        f.lt  = (sa & ~sb) | ((sa == sb) & ult);
        return f;
    endfunction

endpackage

// File: rtl/comparator_sequential_if.sv
// Operand/result handshake bundle for the sequential comparator.
// slave is the comparator's view, master is the producer/consumer view.
interface comparator_sequential_if
    import signals::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
);
    localparam int STEPS = N / CHUNK;
    localparam int SW    = $clog2(STEPS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    compare_t      signal;
    logic [SW-1:0] steps;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, signal, steps
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, signal, steps
    );
endinterface

// File: rtl/comparator_sequential_slice.sv
// Purely combinational CHUNK-bit unsigned slice compare.
module comparator_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             gt,
    output logic             eq
);
    assign gt = (x > y);
    assign eq = (x == y);
endmodule

// File: rtl/comparator_sequential.sv
// Multi-cycle wide comparator: scans the latched operands MSB-first one
// CHUNK-bit slice per cycle and stops at the first differing slice.
module comparator_sequential
    import signals::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    comparator_sequential_if.slave bus
);
    localparam int STEPS = N / CHUNK;
    localparam int SW    = $clog2(STEPS + 1);
    localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] ST_IDLE = CMPS_IDLE;
    localparam logic [1:0] ST_SCAN = CMPS_SCAN;
    localparam logic [1:0] ST_DONE = CMPS_DONE;

    generate
        if ((N % CHUNK) != 0 || CHUNK > N) begin : g_bad_params
            $error("comparator_sequential: N must be a multiple of CHUNK and CHUNK <= N");
        end
    endgenerate

    logic [1:0]       state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [N-1:0]     ra_reg, ra_next;
    logic [N-1:0]     rb_reg, rb_next;
    logic             out_valid_reg, out_valid_next;
    compare_t         signal_reg, signal_next;
    logic [SW-1:0]    steps_reg, steps_next;

    logic [CHUNK-1:0] cur_a, cur_b;
    logic             slice_gt, slice_eq;

    // Slice mux: idx counts from the MSB slice downwards.
    generate
        if (STEPS == 1) begin : g_single_slice
            assign cur_a = ra_reg;
            assign cur_b = rb_reg;
        end else begin : g_slice_mux
            logic [CHUNK-1:0] a_slices [STEPS];
            logic [CHUNK-1:0] b_slices [STEPS];
            logic [IW-1:0]    slice_sel;
            for (genvar gi = 0; gi < STEPS; gi++) begin : g_slices
                assign a_slices[gi] = ra_reg[gi*CHUNK +: CHUNK];
                assign b_slices[gi] = rb_reg[gi*CHUNK +: CHUNK];
            end
            assign slice_sel = IW'(STEPS - 1) - idx_reg;
            assign cur_a     = a_slices[slice_sel];
            assign cur_b     = b_slices[slice_sel];
        end
    endgenerate

    comparator_slice #(.CHUNK(CHUNK)) u_slice (
        .x  (cur_a),
        .y  (cur_b),
        .gt (slice_gt),
        .eq (slice_eq)
    );

    assign bus.in_ready  = (state_reg == ST_IDLE) & ~flush;
    assign bus.out_valid = out_valid_reg;
    assign bus.signal    = signal_reg;
    assign bus.steps     = steps_reg;

    // Next-state logic: accept, per-slice scan with early exit, result hold.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        ra_next        = ra_reg;
        rb_next        = rb_reg;
        out_valid_next = out_valid_reg;
        signal_next    = signal_reg;
        steps_next     = steps_reg;

        if (flush) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
            signal_next    = '0;
            steps_next     = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        ra_next    = bus.a;
                        rb_next    = bus.b;
                        idx_next   = '0;
                        state_next = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!slice_eq || idx_reg == IW'(STEPS - 1)) begin
                        // Equal last slice means equal operands: ugt = ult = 0.
                        signal_next    = make_compare(slice_eq,
                                                      ~slice_eq & slice_gt,
                                                      ~slice_eq & ~slice_gt,
                                                      ra_reg[N-1], rb_reg[N-1]);
                        steps_next     = SW'(idx_reg) + SW'(1);
                        out_valid_next = 1'b1;
                        state_next     = ST_DONE;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_next = 1'b0;
                        state_next     = ST_IDLE;
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            ra_reg        <= '0;
            rb_reg        <= '0;
            out_valid_reg <= 1'b0;
            signal_reg    <= '0;
            steps_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            ra_reg        <= ra_next;
            rb_reg        <= rb_next;
            out_valid_reg <= out_valid_next;
            signal_reg    <= signal_next;
            steps_reg     <= steps_next;
        end
    end

endmodule

// File: tb/tb_comparator_sequential.sv
// Self-checking bench: three comparator instances (CHUNK 8, 1, 32) driven one
// at a time through a selector, checked against an arithmetic reference.
module tb_comparator_sequential;
    import signals::*;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          sel;
    logic        in_valid_s, out_ready_s;
    logic [31:0] a_s, b_s;

    logic     o_valid, o_inready;
    compare_t o_sig;
    int       o_steps;

    comparator_sequential_if #(.N(32), .CHUNK(8))  if8  ();
    comparator_sequential_if #(.N(32), .CHUNK(1))  if1  ();
    comparator_sequential_if #(.N(32), .CHUNK(32)) if32 ();

    assign if8.in_valid   = in_valid_s && (sel == 0);
    assign if1.in_valid   = in_valid_s && (sel == 1);
    assign if32.in_valid  = in_valid_s && (sel == 2);
    assign if8.out_ready  = out_ready_s && (sel == 0);
    assign if1.out_ready  = out_ready_s && (sel == 1);
    assign if32.out_ready = out_ready_s && (sel == 2);
    assign if8.a = a_s;  assign if8.b = b_s;
    assign if1.a = a_s;  assign if1.b = b_s;
    assign if32.a = a_s; assign if32.b = b_s;

    comparator_sequential #(.N(32), .CHUNK(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if8.slave));
    comparator_sequential #(.N(32), .CHUNK(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if1.slave));
    comparator_sequential #(.N(32), .CHUNK(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if32.slave));

    always_comb begin
        o_valid   = if8.out_valid;
        o_inready = if8.in_ready;
        o_sig     = if8.signal;
        o_steps   = int'(if8.steps);
        case (sel)
            1: begin
                o_valid = if1.out_valid; o_inready = if1.in_ready;
                o_sig = if1.signal; o_steps = int'(if1.steps);
            end
            2: begin
                o_valid = if32.out_valid; o_inready = if32.in_ready;
                o_sig = if32.signal; o_steps = int'(if32.steps);
            end
            default: ;
        endcase
    end

    function automatic int chunk_of(input int s);
        return (s == 1) ? 1 : (s == 2) ? 32 : 8;
    endfunction

    // Reference: flags from plain signed/unsigned arithmetic; steps from the
    // position of the highest differing bit.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input int chunk, output compare_t f, output int st);
        logic [31:0] d;
        int h;
        f.eq  = (a == b);
        f.neq = (a != b);
        f.gtu = (a > b);
        f.ltu = (a < b);
        f.gt  = ($signed(a) > $signed(b));
        f.lt  = ($signed(a) < $signed(b));
        d = a ^ b;
        h = -1;
        for (int i = 0; i < 32; i++) if (d[i]) h = i;
        st = (h < 0) ? (32 / chunk) : (32 / chunk - h / chunk);
    endfunction

    task automatic do_compare(input logic [31:0] a, input logic [31:0] b,
                              input int hold, input string name);
        compare_t ef;
        int es, lat;
        model(a, b, chunk_of(sel), ef, es);
        @(negedge clk);
        a_s = a; b_s = b; in_valid_s = 1'b1;
        checks++;
        if (o_inready !== 1'b1) begin
            errors++;
            $display("FAIL %s sel=%0d in_ready before accept: got %b want 1", name, sel, o_inready);
        end
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        a_s = $urandom; b_s = $urandom;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (lat < 0) begin
                @(posedge clk); #1;
                if (o_valid) lat = c;
            end
        end
        checks++;
        if (lat != es) begin
            errors++;
            $display("FAIL %s sel=%0d latency: got %0d want %0d", name, sel, lat, es);
        end
        checks++;
        if (o_steps != es || o_sig !== ef) begin
            errors++;
            $display("FAIL %s sel=%0d result: got steps=%0d sig=%b want steps=%0d sig=%b",
                     name, sel, o_steps, o_sig, es, ef);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_sig !== ef || o_inready !== 1'b0 || o_steps != es) begin
                errors++;
                $display("FAIL %s sel=%0d hold%0d: got v=%b sig=%b rdy=%b want v=1 sig=%b rdy=0",
                         name, sel, h, o_valid, o_sig, o_inready, ef);
            end
        end
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_inready !== 1'b1) begin
            errors++;
            $display("FAIL %s sel=%0d consume: got v=%b rdy=%b want v=0 rdy=1",
                     name, sel, o_valid, o_inready);
        end
        $display("sel=%0d %s a=%h b=%h steps=%0d lat=%0d sig=%b", sel, name, a, b, o_steps, lat, o_sig);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            checks++;
            if (o_valid !== 1'b0 || o_sig !== '0 || o_steps != 0 || o_inready !== 1'b1) begin
                errors++;
                $display("FAIL reset sel=%0d: got v=%b sig=%b steps=%0d rdy=%b want 0/0/0/1",
                         s, o_valid, o_sig, o_steps, o_inready);
            end
            flush = 1'b1; #1;
            checks++;
            if (o_inready !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush sel=%0d in_ready: got %b want 0", s, o_inready);
            end
            flush = 1'b0; #1;
        end
        $display("reset checks done");
    endtask

    task automatic test_directed();
        do_compare(32'h8000_0000, 32'h0000_0000, 0, "msb_diff");
        do_compare(32'h1234_5678, 32'h1234_5679, 0, "lsb_diff");
        do_compare(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, "equal");
        do_compare(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "backpressure");
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = a ^ ({24'h0, 8'($urandom_range(1, 255))} << (8 * $urandom_range(0, 3)));
            endcase
            do_compare(a, b, $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        a_s = 32'd1; b_s = 32'd2; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1; #1;
        checks++;
        if (o_inready !== 1'b0) begin
            errors++;
            $display("FAIL flush sel=%0d in_ready during flush: got %b want 0", sel, o_inready);
        end
        @(posedge clk); #1;
        flush = 1'b0; #1;
        checks++;
        if (o_valid !== 1'b0 || o_sig !== '0 || o_steps != 0 || o_inready !== 1'b1) begin
            errors++;
            $display("FAIL flush sel=%0d after: got v=%b sig=%b steps=%0d rdy=%b want 0/0/0/1",
                     sel, o_valid, o_sig, o_steps, o_inready);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush sel=%0d spurious result cycle %0d: got v=%b want 0", sel, i, o_valid);
            end
        end
        $display("sel=%0d flush aborted scan", sel);
        do_compare(32'd1, 32'd2, 0, "after_flush");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_s = 32'd1; b_s = 32'd2; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0; #1;
        checks++;
        if (o_valid !== 1'b0 || o_sig !== '0 || o_steps != 0 || o_inready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid sel=%0d: got v=%b sig=%b steps=%0d rdy=%b want 0/0/0/1",
                     sel, o_valid, o_sig, o_steps, o_inready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid sel=%0d spurious result cycle %0d: got v=%b want 0", sel, i, o_valid);
            end
        end
        $display("sel=%0d reset mid-scan discarded operation", sel);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; sel = 0;
        in_valid_s = 1'b0; out_ready_s = 1'b0; a_s = '0; b_s = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        sel = 0;
        test_directed();
        test_random(20);
        test_flush();
        test_reset_mid();
        do_compare(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "after_reset");
        sel = 1;
        test_directed();
        test_random(10);
        test_flush();
        test_reset_mid();
        sel = 2;
        test_directed();
        test_random(10);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
